// File: rtl/token_quantizer.sv
// token_quantizer
//
// Purpose: on `start`, takes a snapshot of a flattened L x D matrix of signed
// Q1.15 values and of the L per-token 4-bit precision codes. It then streams
// every element out over a valid/ready interface in token-major order. Each
// element is requantized to the precision code of its token:
//    code 0     : int4 grid (low 12 bits cleared), round half toward +inf,
//                 saturating at 0x7000
//    code 1     : int8 grid (low 8 bits cleared), round half toward +inf,
//                 saturating at 0x7F00
//    codes 2..15: fp16 passthrough (the value is unchanged)
//
// Ports:
//    clk              clock, rising edge
//    rst_n            synchronous active-low reset
//    start            begins a pass; sampled only while idle
//    token_precision  precision code per token [0:L-1]
//    V_in             element (t,e) at bits [(t*D+e+1)*DATA_WIDTH-1 -: DATA_WIDTH]
//    out_valid        out_data holds a valid element
//    out_ready        downstream accepts the presented element
//    out_data         quantized element, still in the Q1.15 container
//    out_token        token index of the presented element
//    out_prec         raw precision code applied to the presented element
//    out_last         high with the final element (t=L-1, e=D-1)
//    busy             pass in progress (load and emit phases)
//    done             one-cycle pulse after the final handshake
//    sat_count        (only with TOKEN_QUANT_STATS_EN) count of handshaked
//                     elements that saturated; held at 0xFFFF
//
// Build option: define TOKEN_QUANT_STATS_EN to add the sat_count output.

module token_quantizer #(
   parameter int DATA_WIDTH = 16,
   parameter int L          = 8,
   parameter int D          = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [3:0]                 token_precision [0:L-1],
   input  logic [DATA_WIDTH*L*D-1:0]  V_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_WIDTH-1:0]      out_data,
   output logic [$clog2(L)-1:0]       out_token,
   output logic [3:0]                 out_prec,
   output logic                       out_last,
   output logic                       busy,
   output logic                       done
`ifdef TOKEN_QUANT_STATS_EN
   ,
   output logic [15:0]                sat_count
`endif
);

   localparam int TW = $clog2(L);
   localparam int EW = (D > 1) ? $clog2(D) : 1;

   localparam logic [TW-1:0] TOK_LAST  = TW'(L - 1);
   localparam logic [EW-1:0] ELEM_LAST = EW'(D - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_EMIT,
      S_DONE
   } state_t;

   state_t                      state, state_nxt;

   logic [DATA_WIDTH*L*D-1:0]   v_lat;
   logic [3:0]                  prec_lat [0:L-1];
   logic                        load_en;

   logic [TW-1:0]               tok, tok_nxt;
   logic [EW-1:0]               elem, elem_nxt;

   logic                        valid_nxt;
   logic [DATA_WIDTH-1:0]       data_nxt;
   logic [TW-1:0]               token_nxt;
   logic [3:0]                  prec_nxt;
   logic                        last_nxt;
   logic                        busy_nxt;
   logic                        done_nxt;

   logic                        present;
   int                          idx;
   logic [DATA_WIDTH-1:0]       src_x;
   logic [3:0]                  src_code;

   // Round-to-grid: add half an LSB of the target grid, then clear the low
   // bits. Only a positive operand can overflow the signed container.
   function automatic logic [DATA_WIDTH-1:0] quantize(
      input logic [DATA_WIDTH-1:0] x,
      input logic [3:0]            code
   );
      logic [DATA_WIDTH:0]   r;
      logic [DATA_WIDTH-1:0] mask;
      logic [DATA_WIDTH-1:0] res;
      int unsigned           k;
      k    = (code == 4'd0) ? 12 : 8;
      r    = {x[DATA_WIDTH-1], x} + ((DATA_WIDTH+1)'(1) << (k - 1));
      mask = {DATA_WIDTH{1'b1}} << k;
      if (code > 4'd1)
         res = x;
      else if (!r[DATA_WIDTH] && r[DATA_WIDTH-1])
         res = {1'b0, {(DATA_WIDTH-1){1'b1}}} & mask;
      else
         res = r[DATA_WIDTH-1:0] & mask;
      return res;
   endfunction

`ifdef TOKEN_QUANT_STATS_EN
   function automatic logic saturates(
      input logic [DATA_WIDTH-1:0] x,
      input logic [3:0]            code
   );
      logic [DATA_WIDTH:0] r;
      int unsigned         k;
      k = (code == 4'd0) ? 12 : 8;
      r = {x[DATA_WIDTH-1], x} + ((DATA_WIDTH+1)'(1) << (k - 1));
      return (code <= 4'd1) && !r[DATA_WIDTH] && r[DATA_WIDTH-1];
   endfunction

   logic out_sat, sat_nxt;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state and next-output logic. Outputs are registered, so the
   // element presented after a handshake is computed here from the
   // advanced indices. During S_LOAD the snapshot is not yet readable, so
   // element (0,0) is taken straight from the inputs being captured.
   always_comb begin
      state_nxt = state;
      tok_nxt   = tok;
      elem_nxt  = elem;
      valid_nxt = out_valid;
      data_nxt  = out_data;
      token_nxt = out_token;
      prec_nxt  = out_prec;
      last_nxt  = out_last;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      load_en   = 1'b0;
      present   = 1'b0;
`ifdef TOKEN_QUANT_STATS_EN
      sat_nxt   = out_sat;
`endif

      case (state)
         S_IDLE: begin
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
            if (start) begin
               state_nxt = S_LOAD;
               busy_nxt  = 1'b1;
            end
         end
         S_LOAD: begin
            state_nxt = S_EMIT;
            load_en   = 1'b1;
            tok_nxt   = '0;
            elem_nxt  = '0;
            present   = 1'b1;
         end
         S_EMIT: begin
            if (out_valid && out_ready) begin
               if (tok == TOK_LAST && elem == ELEM_LAST) begin
                  state_nxt = S_DONE;
                  valid_nxt = 1'b0;
                  last_nxt  = 1'b0;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end else begin
                  if (elem == ELEM_LAST) begin
                     elem_nxt = '0;
                     tok_nxt  = tok + TW'(1);
                  end else begin
                     elem_nxt = elem + EW'(1);
                  end
                  present = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      idx = int'(tok_nxt) * D + int'(elem_nxt);
      if (state == S_LOAD) begin
         src_x    = V_in[DATA_WIDTH-1:0];
         src_code = token_precision[0];
      end else begin
         src_x    = v_lat[idx*DATA_WIDTH +: DATA_WIDTH];
         src_code = prec_lat[tok_nxt];
      end

      if (present) begin
         valid_nxt = 1'b1;
         data_nxt  = quantize(src_x, src_code);
         token_nxt = tok_nxt;
         prec_nxt  = src_code;
         last_nxt  = (tok_nxt == TOK_LAST) && (elem_nxt == ELEM_LAST);
`ifdef TOKEN_QUANT_STATS_EN
         sat_nxt   = saturates(src_x, src_code);
`endif
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_lat     <= '0;
         for (int unsigned t = 0; t < L; t++)
            prec_lat[t] <= '0;
         tok       <= '0;
         elem      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_token <= '0;
         out_prec  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         if (load_en) begin
            v_lat <= V_in;
            for (int unsigned t = 0; t < L; t++)
               prec_lat[t] <= token_precision[t];
         end
         tok       <= tok_nxt;
         elem      <= elem_nxt;
         out_valid <= valid_nxt;
         out_data  <= data_nxt;
         out_token <= token_nxt;
         out_prec  <= prec_nxt;
         out_last  <= last_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

`ifdef TOKEN_QUANT_STATS_EN
   // The saturation flag travels with the presented element so the count
   // advances only when that element is actually accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_sat   <= 1'b0;
         sat_count <= '0;
      end else begin
         out_sat <= sat_nxt;
         if (state == S_LOAD)
            sat_count <= '0;
         else if (state == S_EMIT && out_valid && out_ready && out_sat &&
                  sat_count != 16'hFFFF)
            sat_count <= sat_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_token_quantizer.sv
// tb_token_quantizer
//
// Purpose: self-checking bench for token_quantizer (L=8, D=4, 16-bit).
// Expected elements are pushed to a scoreboard queue when a pass is set up
// and popped on every output handshake. sat_count is checked when
// TOKEN_QUANT_STATS_EN is defined.

module tb_token_quantizer;

   localparam int DW = 16;
   localparam int L  = 8;
   localparam int D  = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [2:0]    token;
      logic [3:0]    prec;
      logic          last;
      logic          sat;
   } exp_t;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [3:0]        prec [0:L-1];
   logic [DW*L*D-1:0] v_in;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_data;
   logic [2:0]        out_token;
   logic [3:0]        out_prec;
   logic              out_last;
   logic              busy;
   logic              done;
`ifdef TOKEN_QUANT_STATS_EN
   logic [15:0]       sat_count;
`endif

   exp_t q[$];
   int   exp_sat;
   int   vectors;
   int   miscompares;

   token_quantizer #(
      .DATA_WIDTH (DW),
      .L          (L),
      .D          (D)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .token_precision (prec),
      .V_in            (v_in),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_token       (out_token),
      .out_prec        (out_prec),
      .out_last        (out_last),
      .busy            (busy),
      .done            (done)
`ifdef TOKEN_QUANT_STATS_EN
      ,
      .sat_count       (sat_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference requantizer written from the arithmetic definition.
   function automatic exp_t model(input int t, input int e,
                                  input logic [15:0] x, input logic [3:0] c);
      exp_t m;
      int   xi;
      int   k;
      int   r;
      xi    = int'($signed(x));
      m.sat = 1'b0;
      if (c == 4'd0 || c == 4'd1) begin
         k = (c == 4'd0) ? 12 : 8;
         r = xi + (1 << (k - 1));
         if (r > 32767) begin
            r     = 32767;
            m.sat = 1'b1;
         end
         r      = r & ~((1 << k) - 1);
         m.data = r[15:0];
      end else begin
         m.data = x;
      end
      m.token = t[2:0];
      m.prec  = c;
      m.last  = (t == L - 1) && (e == D - 1);
      return m;
   endfunction

   task automatic push_expected;
      exp_t m;
      exp_sat = 0;
      for (int t = 0; t < L; t++) begin
         for (int e = 0; e < D; e++) begin
            m = model(t, e, v_in[(t*D+e)*DW +: DW], prec[t]);
            if (m.sat && exp_sat < 65535)
               exp_sat++;
            q.push_back(m);
         end
      end
   endtask

   task automatic randomize_inputs(input int max_code);
      for (int t = 0; t < L; t++) begin
         prec[t] = 4'($urandom_range(0, max_code));
         for (int e = 0; e < D; e++)
            v_in[(t*D+e)*DW +: DW] = 16'($urandom());
      end
   endtask

   // Starts a pass and drains it against the scoreboard.
   // rnd: random out_ready; kill_at: reset when that element would be
   // accepted (-1 = never); poke_at: cycle at which start is re-pulsed and
   // the inputs are scrambled (-1 = never).
   task automatic run_pass(input bit rnd, input int kill_at, input int poke_at);
      exp_t        e;
      int          popped;
      bit          got_last;
      bit          h_valid;
      bit          h_ready;
      logic [23:0] h_fields;
      popped   = 0;
      got_last = 1'b0;
      h_valid  = 1'b0;
      h_ready  = 1'b1;
      h_fields = '0;

      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      vectors++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL load_cycle: busy=%b out_valid=%b expected busy=1 out_valid=0",
                  busy, out_valid);
      end

      for (int cyc = 0; cyc < 400 && !got_last; cyc++) begin
         @(negedge clk);
         if (poke_at >= 0 && cyc == poke_at) begin
            start = 1'b1;
            randomize_inputs(15);
         end else begin
            start = 1'b0;
         end
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;

         if (h_valid && !h_ready) begin
            vectors++;
            if ({out_valid, out_data, out_token, out_prec, out_last} !== {1'b1, h_fields}) begin
               miscompares++;
               $display("FAIL stall_hold: got valid=%b %h/%0d/%0d/%b expected held %h/%0d/%0d/%b",
                        out_valid, out_data, out_token, out_prec, out_last,
                        h_fields[23:8], h_fields[7:5], h_fields[4:1], h_fields[0]);
            end
         end

         if (out_valid) begin
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0) begin
               miscompares++;
               $display("FAIL busy_during_emit: busy=%b done=%b expected 1/0", busy, done);
            end
            if (out_ready) begin
               if (kill_at >= 0 && popped == kill_at) begin
                  rst_n = 1'b0;
                  @(negedge clk);
                  rst_n     = 1'b1;
                  out_ready = 1'b1;
                  vectors++;
                  if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_data !== '0) begin
                     miscompares++;
                     $display("FAIL midstream_reset: valid=%b busy=%b done=%b data=%h expected all 0",
                              out_valid, busy, done, out_data);
                  end
                  q.delete();
                  return;
               end
               vectors++;
               if (q.size() == 0) begin
                  miscompares++;
                  $display("FAIL extra_output: got %h token %0d with empty scoreboard",
                           out_data, out_token);
               end else begin
                  e = q.pop_front();
                  if ({out_data, out_token, out_prec, out_last} !== {e.data, e.token, e.prec, e.last}) begin
                     miscompares++;
                     $display("FAIL element_%0d: got data=%h tok=%0d prec=%0d last=%b expected data=%h tok=%0d prec=%0d last=%b",
                              popped, out_data, out_token, out_prec, out_last,
                              e.data, e.token, e.prec, e.last);
                  end
                  popped++;
                  if (e.last)
                     got_last = 1'b1;
               end
            end
         end
         h_valid  = out_valid;
         h_ready  = out_ready;
         h_fields = {out_data, out_token, out_prec, out_last};
      end

      start = 1'b0;
      vectors++;
      if (!got_last) begin
         miscompares++;
         $display("FAIL pass_timeout: got %0d elements expected %0d", popped, L*D);
      end else begin
         @(negedge clk);
         vectors++;
         if (done !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: done=%b out_valid=%b expected 1/0", done, out_valid);
         end
`ifdef TOKEN_QUANT_STATS_EN
         vectors++;
         if (sat_count !== 16'(exp_sat)) begin
            miscompares++;
            $display("FAIL sat_count: got %0d expected %0d", sat_count, exp_sat);
         end
`endif
         @(negedge clk);
         vectors++;
         if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_width: done=%b expected 0", done);
         end
      end
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_left: got %0d unconsumed expected 0", q.size());
      end
      q.delete();
      out_ready = 1'b1;
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;
      for (int t = 0; t < L; t++) prec[t] = 4'd2;
      v_in = '0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({out_valid, out_data, out_token, out_prec, out_last, busy, done} !== 27'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got v=%b d=%h t=%0d p=%0d l=%b b=%b dn=%b expected all 0",
                  out_valid, out_data, out_token, out_prec, out_last, busy, done);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_after_reset: valid=%b busy=%b expected 0/0", out_valid, busy);
      end
   endtask

   task automatic test_passthrough;
      for (int t = 0; t < L; t++) begin
         prec[t] = 4'd2;
         for (int e = 0; e < D; e++)
            v_in[(t*D+e)*DW +: DW] = 16'(t*4 + e);
      end
      push_expected();
      run_pass(1'b0, -1, -1);
   endtask

   task automatic test_int4;
      randomize_inputs(15);
      for (int t = 1; t < L; t++) prec[t] = 4'd3;
      prec[0] = 4'd0;
      v_in[0*DW +: DW] = 16'h0800;
      v_in[1*DW +: DW] = 16'h07FF;
      v_in[2*DW +: DW] = 16'h7900;
      v_in[3*DW +: DW] = 16'h8000;
      push_expected();
      run_pass(1'b0, -1, -1);
   endtask

   task automatic test_int8;
      randomize_inputs(15);
      for (int t = 0; t < L; t++) prec[t] = 4'd15;
      prec[1] = 4'd1;
      v_in[4*DW +: DW] = 16'h0080;
      v_in[5*DW +: DW] = 16'hFF7F;
      v_in[6*DW +: DW] = 16'h7FF0;
      v_in[7*DW +: DW] = 16'h8000;
      push_expected();
      run_pass(1'b0, -1, -1);
   endtask

   task automatic test_stall;
      randomize_inputs(3);
      push_expected();
      run_pass(1'b1, -1, -1);
      push_expected();
      run_pass(1'b0, -1, -1);
   endtask

   task automatic test_ignore_start;
      randomize_inputs(3);
      push_expected();
      run_pass(1'b1, -1, 5);
      repeat (4) begin
         @(negedge clk);
         vectors++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_not_queued: valid=%b busy=%b expected 0/0", out_valid, busy);
         end
      end
   endtask

   task automatic test_midreset;
      randomize_inputs(3);
      push_expected();
      run_pass(1'b0, 10, -1);
      repeat (3) begin
         @(negedge clk);
         vectors++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset_idle: valid=%b busy=%b expected 0/0", out_valid, busy);
         end
      end
      randomize_inputs(3);
      push_expected();
      run_pass(1'b0, -1, -1);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      exp_sat     = 0;
      test_reset();
      test_passthrough();
      test_int4();
      test_int8();
      test_stall();
      test_ignore_start();
      test_midreset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
